fetch_controller: RTL and testbench

//  Fetch sequencer for the synchronous instruction memory (1-cycle registered read, byte-addressed, big-endian word).

---
 rtl/fetch_controller.sv | 101 ++++++++++
 tb/tb_fetch_controller.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_controller.sv
// Fetch sequencer: owns the PC, issues imem reads and offers tagged words to decode.
// Latency: the word for an address issued at edge E is offered in the cycle after E.
// Backpressure: !instr_ready parks the returning word in a 1-entry skid; draining it costs one bubble.
module fetch_controller #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        halted
);

    typedef enum logic [1:0] {IDLE, RUN, STALL, HALT} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic        rsp_valid, rsp_valid_nxt;
    logic [31:0] rsp_pc, rsp_pc_nxt;
    logic        skid_valid, skid_valid_nxt;
    logic [31:0] skid_instr, skid_instr_nxt;
    logic [31:0] skid_pc, skid_pc_nxt;
    logic        issue;
    logic        xfer;

    assign imem_addr   = pc;
    assign halted      = (state == HALT);
    assign instr_valid = (skid_valid | rsp_valid) & ~redirect_valid;
    assign instr       = skid_valid ? skid_instr : imem_rdata;
    assign instr_pc    = skid_valid ? skid_pc : rsp_pc;
    assign xfer        = instr_valid & instr_ready;
    assign issue       = (state == RUN) & ~skid_valid & ~(rsp_valid & ~instr_ready) & ~redirect_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            rsp_valid  <= 1'b0;
            rsp_pc     <= 32'd0;
            skid_valid <= 1'b0;
            skid_instr <= 32'd0;
            skid_pc    <= 32'd0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            rsp_valid  <= rsp_valid_nxt;
            rsp_pc     <= rsp_pc_nxt;
            skid_valid <= skid_valid_nxt;
            skid_instr <= skid_instr_nxt;
            skid_pc    <= skid_pc_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        rsp_valid_nxt  = 1'b0;
        rsp_pc_nxt     = rsp_pc;
        skid_valid_nxt = skid_valid;
        skid_instr_nxt = skid_instr;
        skid_pc_nxt    = skid_pc;

        if (redirect_valid) begin
            pc_nxt         = redirect_pc & ~32'd3;
            skid_valid_nxt = 1'b0;
            state_nxt      = RUN;
        end else if (xfer && (instr == HALT_WORD)) begin
            // The word fetched behind HALT is dropped; resume point is just after it.
            pc_nxt         = instr_pc + 32'd4;
            skid_valid_nxt = 1'b0;
            state_nxt      = HALT;
        end else if (rsp_valid && !skid_valid && !instr_ready) begin
            // imem re-reads every edge, so the unaccepted word must be captured now.
            skid_valid_nxt = 1'b1;
            skid_instr_nxt = imem_rdata;
            skid_pc_nxt    = rsp_pc;
            state_nxt      = STALL;
        end else if (skid_valid && xfer) begin
            skid_valid_nxt = 1'b0;
            state_nxt      = RUN;
        end else begin
            if (((state == IDLE) || (state == HALT)) && start) begin
                state_nxt = RUN;
            end
            if (issue) begin
                rsp_valid_nxt = 1'b1;
                rsp_pc_nxt    = pc;
                pc_nxt        = pc + 32'd4;
            end
        end
    end

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: directed scenarios plus random traffic, all transfers
// scored against a stream-level model (expected next PC, halted/idle, offer stability).
module tb_fetch_controller;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        halted;

    int n_chk = 0;
    int n_err = 0;
    int n_xfer = 0;

    fetch_controller #(.RESET_PC(RESET_PC), .HALT_WORD(HALT_WORD)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .halted         (halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h00:  mem_word = 32'h2149FF00;
            32'h04:  mem_word = 32'h2149FF04;
            32'h08:  mem_word = 32'h014B4808;
            32'h0C:  mem_word = 32'h014B4812;
            32'h10:  mem_word = 32'h014B4816;
            32'h14:  mem_word = HALT_WORD;
            32'h30:  mem_word = 32'h2149FF48;
            default: mem_word = {4'h1, a[27:0]};
        endcase
    endfunction

    always @(posedge clk) imem_rdata <= mem_word(imem_addr);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Stream model: which PC must be delivered next and whether fetch is stopped.
    logic [31:0] m_pc      = RESET_PC;
    logic        m_stopped = 1'b1;
    logic        m_halt    = 1'b0;
    logic        have_offer = 1'b0;
    logic [31:0] off_pc, off_instr;

    always @(negedge clk) begin
        if (reset) begin
            chk("mon_rst_valid", 32'(instr_valid), 32'd0);
            chk("mon_rst_halted", 32'(halted), 32'd0);
            chk("mon_rst_addr", imem_addr, RESET_PC);
            m_pc = RESET_PC;
            m_stopped = 1'b1;
            m_halt = 1'b0;
            have_offer = 1'b0;
        end else begin
            chk("mon_halted", 32'(halted), 32'(m_stopped && m_halt));
            if (m_stopped) chk("mon_stopped_valid", 32'(instr_valid), 32'd0);
            if (have_offer && !redirect_valid) begin
                chk("mon_hold_valid", 32'(instr_valid), 32'd1);
                chk("mon_hold_pc", instr_pc, off_pc);
                chk("mon_hold_instr", instr, off_instr);
            end
            if (redirect_valid) begin
                chk("mon_redir_mask", 32'(instr_valid), 32'd0);
                m_pc = redirect_pc & ~32'd3;
                m_stopped = 1'b0;
                m_halt = 1'b0;
                have_offer = 1'b0;
            end else begin
                if (m_stopped && start) begin
                    m_stopped = 1'b0;
                    m_halt = 1'b0;
                end
                if (instr_valid && instr_ready) begin
                    chk("mon_xfer_pc", instr_pc, m_pc);
                    chk("mon_xfer_instr", instr, mem_word(m_pc));
                    n_xfer++;
                    if (mem_word(m_pc) == HALT_WORD) begin
                        m_stopped = 1'b1;
                        m_halt = 1'b1;
                    end
                    m_pc = m_pc + 32'd4;
                    have_offer = 1'b0;
                end else if (instr_valid) begin
                    have_offer = 1'b1;
                    off_pc = instr_pc;
                    off_instr = instr;
                end else begin
                    have_offer = 1'b0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_word(input string tag, input logic [31:0] pc);
        @(negedge clk);
        chk({tag, "_valid"}, 32'(instr_valid), 32'd1);
        chk({tag, "_pc"}, instr_pc, pc);
        chk({tag, "_instr"}, instr, mem_word(pc));
    endtask

    task automatic expect_idle(input string tag);
        @(negedge clk);
        chk(tag, 32'(instr_valid), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'd0;
        instr_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_addr", imem_addr, RESET_PC);
        step();
        reset = 1'b0;

        // Start, first word two cycles later, then full throughput.
        start = 1'b1;
        step();
        start = 1'b0;
        instr_ready = 1'b1;
        expect_idle("t1_first_latency");
        step();
        for (int i = 0; i < 5; i++) begin
            expect_word("t1_seq", 32'(4 * i));
            step();
        end

        // HALT word is delivered, then nothing until start resumes at 0x18.
        expect_word("t4_halt_word", 32'h14);
        step();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_halted", 32'(halted), 32'd1);
            chk("t4_no_valid", 32'(instr_valid), 32'd0);
            chk("t4_addr", imem_addr, 32'h18);
            step();
        end
        start = 1'b1;
        step();
        start = 1'b0;
        expect_idle("t4_resume_gap");
        step();
        expect_word("t4_resume", 32'h18);
        step();

        // Backpressure on 0x8: held for 3 cycles, one bubble, then 0xC, 0x10.
        redirect_valid = 1'b1;
        redirect_pc = 32'h0;
        expect_idle("t2_redir_mask");
        step();
        redirect_valid = 1'b0;
        expect_idle("t2_redir_gap");
        step();
        expect_word("t2_w0", 32'h0);
        step();
        expect_word("t2_w4", 32'h4);
        step();
        instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            expect_word("t2_stall", 32'h8);
            chk("t2_addr_frozen", imem_addr, 32'hC);
            step();
        end
        instr_ready = 1'b1;
        expect_word("t2_drain", 32'h8);
        step();
        expect_idle("t2_bubble");
        step();
        expect_word("t2_after_c", 32'hC);
        step();
        expect_word("t2_after_10", 32'h10);
        step();

        // Redirect to 0x33 while 0x8 is being returned.
        redirect_valid = 1'b1;
        redirect_pc = 32'h0;
        expect_idle("t3_redir0_mask");
        step();
        redirect_valid = 1'b0;
        step();
        expect_word("t3_w0", 32'h0);
        step();
        expect_word("t3_w4", 32'h4);
        step();
        redirect_valid = 1'b1;
        redirect_pc = 32'h33;
        expect_idle("t3_mask_8");
        step();
        redirect_valid = 1'b0;
        expect_idle("t3_gap");
        step();
        expect_word("t3_target", 32'h30);
        step();

        // PC wrap.
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        step();
        expect_word("t6_top", 32'hFFFF_FFFC);
        step();
        expect_word("t6_wrap", 32'h0);
        step();

        // Async reset while a word sits in the skid buffer.
        instr_ready = 1'b0;
        expect_word("t5_pre", 32'h4);
        step();
        #1 reset = 1'b1;
        #1;
        chk("t5_async_valid", 32'(instr_valid), 32'd0);
        chk("t5_async_addr", imem_addr, RESET_PC);
        chk("t5_async_halted", 32'(halted), 32'd0);
        step();
        reset = 1'b0;
        instr_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        expect_word("t5_restart", RESET_PC);
        step();

        // Random traffic, scored by the monitor.
        for (int i = 0; i < 4000; i++) begin
            instr_ready = ($urandom % 4) != 0;
            start = ($urandom % 6) == 0;
            redirect_valid = ($urandom % 25) == 0;
            redirect_pc = (($urandom % 4) == 0) ? $urandom : $urandom_range(0, 31);
            reset = ($urandom % 500) == 0;
            step();
        end
        reset = 1'b0;
        redirect_valid = 1'b0;
        start = 1'b0;
        step();
        chk("rand_enough_xfers", 32'(n_xfer > 200), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
